// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receive (and transmit) sides: receiver FSM
// state encoding, legal oversampling ratios, parity type encoding, frame
// bit-count constants and a helper that maps an arbitrary PRESCALE request
// onto a supported ratio.
// Ports: none (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int FRAME_START_BITS  = 1;
    localparam int FRAME_DATA_BITS   = 8;
    localparam int FRAME_STOP_BITS   = 1;
    localparam int FRAME_BITS_NO_PAR = FRAME_START_BITS + FRAME_DATA_BITS + FRAME_STOP_BITS;
    localparam int FRAME_BITS_PAR    = FRAME_BITS_NO_PAR + 1;

    // Unsupported ratios fall back to the slowest-oversampling legal value.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: legal_prescale = p;
            default:                              legal_prescale = PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit timing for the UART receiver: an edge counter running 0..P-1 inside
// each bit period, a 3-point majority sampler around mid-bit, and the
// bit_end / sample_done pulses the receiver FSM steps on.
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   rx_s_i        synchronised serial line
//   run_i         1 = counter advances this cycle, 0 = counter cleared
//   prescale_i    oversampling ratio P in effect (8/16/32)
//   bit_end_o     combinational, high on edge count P-1
//   sample_done_o registered pulse, high the cycle after edge P/2+1
//   sample_bit_o  2-of-3 majority of samples at P/2-1, P/2, P/2+1
// -----------------------------------------------------------------------------
module uart_rx_sampler (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_s_i,
    input  logic       run_i,
    input  logic [5:0] prescale_i,
    output logic       bit_end_o,
    output logic       sample_done_o,
    output logic       sample_bit_o
);

    logic [4:0] edge_cnt_q, edge_cnt_d;
    logic [5:0] edge_ext, half;
    logic       at_s0, at_s1, at_s2;
    logic       s0_q, s1_q, sample_bit_q, sample_done_q;
    logic       maj;

    assign edge_ext  = {1'b0, edge_cnt_q};
    assign half      = prescale_i >> 1;
    assign bit_end_o = (edge_ext == prescale_i - 6'd1);
    assign at_s0     = (edge_ext == half - 6'd1);
    assign at_s1     = (edge_ext == half);
    assign at_s2     = (edge_ext == half + 6'd1);

    // Third sample is taken live, so the vote is ready on edge P/2+1 itself.
    assign maj = (s0_q & s1_q) | (s0_q & rx_s_i) | (s1_q & rx_s_i);

    always_comb begin
        edge_cnt_d = '0;
        if (run_i) begin
            edge_cnt_d = bit_end_o ? 5'd0 : edge_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_q    <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            sample_bit_q  <= 1'b1;
            sample_done_q <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            sample_done_q <= run_i && at_s2;
            if (run_i && at_s0) s0_q <= rx_s_i;
            if (run_i && at_s1) s1_q <= rx_s_i;
            if (run_i && at_s2) sample_bit_q <= maj;
        end
    end

    assign sample_done_o = sample_done_q;
    assign sample_bit_o  = sample_bit_q;

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, optional parity,
// 1 stop. PRESCALE-times oversampling on CLK.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   RX_IN         asynchronous serial line (idles high)
//   PRESCALE      oversampling ratio (8/16/32; others treated as 8)
//   PAR_EN        parity bit present
//   PAR_TYP       0 = even, 1 = odd
//   P_DATA        last good received byte
//   DATA_VALID    one-cycle strobe, P_DATA updated this cycle
//   PAR_ERR       one-cycle strobe, parity mismatch on the frame just ended
//   STP_ERR       one-cycle strobe, stop bit sampled as 0
//   DBG_STATE     current receiver FSM state (rx_state_t encoding)
// Handshake: DATA_VALID/PAR_ERR/STP_ERR are single-cycle pulses with no
// back-pressure; a consumer must take P_DATA in the cycle DATA_VALID is high.
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic [2:0]            DBG_STATE
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_t              state_q, state_d;
    logic [5:0]             presc_q, presc_eff;
    logic                   par_en_q, par_typ_q;
    logic [DATA_WIDTH-1:0]  shift_q, p_data_q;
    logic [BCW-1:0]         bit_cnt_q;
    logic                   par_fail_q, stop_bit_q;
    logic                   dv_q, par_err_q, stp_err_q;
    logic                   bit_end, sample_done, sample_bit, last_bit;
    logic                   detect, run, frame_end, frame_good;
    logic                   shift_en, bit_cnt_inc, par_chk, stop_smp;

    // Input synchroniser; presets to the idle level so reset never looks like a start.
    always_ff @(posedge CLK) begin
        if (RST) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    // In IDLE the live request drives the counter compare so the detect cycle
    // already counts as edge 0 with the ratio about to be latched.
    assign presc_eff = (state_q == ST_IDLE) ? legal_prescale(PRESCALE) : presc_q;
    assign last_bit  = (bit_cnt_q == BCW'(DATA_WIDTH - 1));

    uart_rx_sampler u_sampler (
        .clk_i         (CLK),
        .rst_i         (RST),
        .rx_s_i        (rx_s),
        .run_i         (run),
        .prescale_i    (presc_eff),
        .bit_end_o     (bit_end),
        .sample_done_o (sample_done),
        .sample_bit_o  (sample_bit)
    );

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!rx_s) state_d = ST_START;
            ST_START: begin
                // A start bit that votes high at mid-bit was a glitch.
                if (sample_done && sample_bit) state_d = ST_IDLE;
                else if (bit_end)              state_d = ST_DATA;
            end
            ST_DATA:   if (bit_end && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs / datapath controls
    always_comb begin
        detect      = (state_q == ST_IDLE) && !rx_s;
        run         = (state_d != ST_IDLE);
        frame_end   = (state_q == ST_STOP) && bit_end;
        shift_en    = (state_q == ST_DATA) && sample_done;
        bit_cnt_inc = (state_q == ST_DATA) && bit_end;
        par_chk     = (state_q == ST_PARITY) && sample_done;
        stop_smp    = (state_q == ST_STOP) && sample_done;
        frame_good  = stop_bit_q && !par_fail_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q    <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_fail_q <= 1'b0;
            stop_bit_q <= 1'b1;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            if (detect) begin
                presc_q    <= legal_prescale(PRESCALE);
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                par_fail_q <= 1'b0;
                bit_cnt_q  <= '0;
            end
            if (shift_en)    shift_q   <= {sample_bit, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt_inc) bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            if (par_chk && (sample_bit != ((^shift_q) ^ par_typ_q))) par_fail_q <= 1'b1;
            if (stop_smp)    stop_bit_q <= sample_bit;
            dv_q      <= frame_end && frame_good;
            stp_err_q <= frame_end && !stop_bit_q;
            par_err_q <= frame_end && par_fail_q;
            if (frame_end && frame_good) p_data_q <= shift_q;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core. Frames are driven bit-by-bit on RX_IN; a
// negedge monitor logs every strobe with its cycle number. Strobes are
// expected SYNC_STAGES(2) + N*P cycles after the cycle the start bit is driven.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err;
    logic [2:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int         dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];
    int         pe_cyc_q[$];
    int         se_cyc_q[$];
    logic [7:0] exp_q[$];

    uart_rx_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .PRESCALE   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_ERR    (par_err),
        .STP_ERR    (stp_err),
        .DBG_STATE  (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (data_valid !== 1'b0) begin
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(p_data);
        end
        if (par_err !== 1'b0) pe_cyc_q.push_back(cyc);
        if (stp_err !== 1'b0) se_cyc_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        dv_cyc_q.delete();
        dv_dat_q.delete();
        pe_cyc_q.delete();
        se_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int p, input bit noise);
        for (int i = 0; i < p; i++) begin
            rx_in = (noise && i == p / 2) ? ~b : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit with_par,
                              input logic par_bit, input logic stop_bit, input bit noise,
                              output int c0);
        c0 = cyc;
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, noise);
        if (with_par) drive_bit(par_bit, p, 1'b0);
        drive_bit(stop_bit, p, 1'b0);
        rx_in = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b want 0", par_err); end
        n_vec++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL reset_se: got %b want 0", stp_err); end
        n_vec++; if (p_data !== 8'h00) begin n_err++; $display("FAIL reset_pdata: got %h want 00", p_data); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic_p8();
        int c0;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        clear_mon();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 1) begin n_err++; $display("FAIL basic_dv_count: got %0d want 1", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 82) begin n_err++; $display("FAIL basic_dv_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 82); end
            n_vec++; if (dv_dat_q[0] !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", dv_dat_q[0]); end
        end
        n_vec++; if (pe_cyc_q.size() + se_cyc_q.size() != 0) begin n_err++; $display("FAIL basic_err_flags: got %0d want 0", pe_cyc_q.size() + se_cyc_q.size()); end
        n_vec++; if (p_data !== 8'hA5) begin n_err++; $display("FAIL basic_pdata_hold: got %h want a5", p_data); end
    endtask

    task automatic test_parity();
        int c0;
        prescale = 6'd16; par_en = 1'b1; par_typ = PAR_EVEN;
        // 0x3C has four ones -> even parity bit 0
        clear_mon();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, c0);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 1) begin n_err++; $display("FAIL par_ok_dv_count: got %0d want 1", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 178) begin n_err++; $display("FAIL par_ok_dv_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 178); end
            n_vec++; if (dv_dat_q[0] !== 8'h3C) begin n_err++; $display("FAIL par_ok_data: got %h want 3c", dv_dat_q[0]); end
        end
        n_vec++; if (pe_cyc_q.size() != 0) begin n_err++; $display("FAIL par_ok_pe: got %0d want 0", pe_cyc_q.size()); end
        // wrong parity bit
        clear_mon();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, c0);
        idle(6);
        n_vec++;
        if (pe_cyc_q.size() != 1) begin n_err++; $display("FAIL par_bad_pe_count: got %0d want 1", pe_cyc_q.size()); end
        else begin
            n_vec++; if (pe_cyc_q[0] != c0 + 178) begin n_err++; $display("FAIL par_bad_pe_cycle: got %0d want %0d", pe_cyc_q[0], c0 + 178); end
        end
        n_vec++; if (dv_cyc_q.size() != 0) begin n_err++; $display("FAIL par_bad_dv: got %0d want 0", dv_cyc_q.size()); end
        n_vec++; if (se_cyc_q.size() != 0) begin n_err++; $display("FAIL par_bad_se: got %0d want 0", se_cyc_q.size()); end
        n_vec++; if (p_data !== 8'h3C) begin n_err++; $display("FAIL par_bad_pdata_hold: got %h want 3c", p_data); end
    endtask

    task automatic test_stop_and_noise();
        int c0;
        prescale = 6'd32; par_en = 1'b1; par_typ = PAR_ODD;
        // 0xFF: eight ones -> odd parity bit 1 (correct), stop forced to 0
        clear_mon();
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, c0);
        idle(6);
        n_vec++;
        if (se_cyc_q.size() != 1) begin n_err++; $display("FAIL stop_se_count: got %0d want 1", se_cyc_q.size()); end
        else begin
            n_vec++; if (se_cyc_q[0] != c0 + 354) begin n_err++; $display("FAIL stop_se_cycle: got %0d want %0d", se_cyc_q[0], c0 + 354); end
        end
        n_vec++; if (dv_cyc_q.size() != 0) begin n_err++; $display("FAIL stop_dv: got %0d want 0", dv_cyc_q.size()); end
        n_vec++; if (pe_cyc_q.size() != 0) begin n_err++; $display("FAIL stop_pe: got %0d want 0", pe_cyc_q.size()); end
        // 0x81: two ones -> odd parity bit 1; one noisy sample at mid-bit of every data bit
        clear_mon();
        send_frame(8'h81, 32, 1'b1, 1'b1, 1'b1, 1'b1, c0);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 1) begin n_err++; $display("FAIL noise_dv_count: got %0d want 1", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 354) begin n_err++; $display("FAIL noise_dv_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 354); end
            n_vec++; if (dv_dat_q[0] !== 8'h81) begin n_err++; $display("FAIL noise_data: got %h want 81", dv_dat_q[0]); end
        end
        n_vec++; if (pe_cyc_q.size() + se_cyc_q.size() != 0) begin n_err++; $display("FAIL noise_err_flags: got %0d want 0", pe_cyc_q.size() + se_cyc_q.size()); end
    endtask

    task automatic test_glitch();
        int c0;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        clear_mon();
        rx_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        idle(20);
        n_vec++; if (dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() != 0) begin n_err++; $display("FAIL glitch_strobes: got %0d want 0", dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size()); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want 0", dbg_state); end
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 1) begin n_err++; $display("FAIL glitch_next_count: got %0d want 1", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 82) begin n_err++; $display("FAIL glitch_next_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 82); end
            n_vec++; if (dv_dat_q[0] !== 8'h55) begin n_err++; $display("FAIL glitch_next_data: got %h want 55", dv_dat_q[0]); end
        end
    endtask

    task automatic test_illegal_prescale();
        int c0;
        prescale = 6'd12; par_en = 1'b0; par_typ = 1'b0;
        clear_mon();
        send_frame(8'h3A, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 1) begin n_err++; $display("FAIL illegal_p_count: got %0d want 1", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 82) begin n_err++; $display("FAIL illegal_p_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 82); end
            n_vec++; if (dv_dat_q[0] !== 8'h3A) begin n_err++; $display("FAIL illegal_p_data: got %h want 3a", dv_dat_q[0]); end
        end
        prescale = 6'd8;
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        logic [7:0] exp_b;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        clear_mon();
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1, 1'b0, c1);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 82) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 82); end
            n_vec++; if (dv_cyc_q[1] - dv_cyc_q[0] != 80) begin n_err++; $display("FAIL b2b_spacing: got %0d want 80", dv_cyc_q[1] - dv_cyc_q[0]); end
            for (int i = 0; i < 2; i++) begin
                exp_b = exp_q.pop_front();
                n_vec++; if (dv_dat_q[i] !== exp_b) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, dv_dat_q[i], exp_b); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        logic [7:0] d;
        d = 8'hC3;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        clear_mon();
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 8, 1'b0);
        for (int i = 0; i < 4; i++) begin rx_in = d[4]; @(posedge clk); #1; end
        n_vec++; if (dbg_state !== ST_DATA) begin n_err++; $display("FAIL midrst_pre_state: got %0d want 2", dbg_state); end
        rst = 1'b1;
        rx_in = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
        n_vec++; if ({data_valid, par_err, stp_err} !== 3'b000) begin n_err++; $display("FAIL midrst_strobes: got %b want 000", {data_valid, par_err, stp_err}); end
        n_vec++; if (p_data !== 8'h00) begin n_err++; $display("FAIL midrst_pdata: got %h want 00", p_data); end
        rst = 1'b0;
        idle(100);
        n_vec++; if (dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() != 0) begin n_err++; $display("FAIL midrst_no_strobe: got %0d want 0", dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size()); end
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        idle(6);
        n_vec++;
        if (dv_cyc_q.size() != 1) begin n_err++; $display("FAIL midrst_next_count: got %0d want 1", dv_cyc_q.size()); end
        else begin
            n_vec++; if (dv_cyc_q[0] != c0 + 82) begin n_err++; $display("FAIL midrst_next_cycle: got %0d want %0d", dv_cyc_q[0], c0 + 82); end
            n_vec++; if (dv_dat_q[0] !== 8'hC3) begin n_err++; $display("FAIL midrst_next_data: got %h want c3", dv_dat_q[0]); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_p8();
        test_parity();
        test_stop_and_noise();
        test_glitch();
        test_illegal_prescale();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver; downstream consumer of the TX serial line (TX_OUT of the UART TX top) in loopback and system paths. Recovers frames in the same format the transmitter produces: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1). Uses PRESCALE-times oversampling on the single system clock. Delivers the parallel byte with a one-cycle valid strobe and per-frame parity and stop error flags.

Parameters:
DATA_WIDTH, 8, data bits per frame
SYNC_STAGES, 2, input synchroniser depth on RX_IN

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  reset, synchronous, active-high
RX_IN  input  1  asynchronous serial line; idles high
PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present in frame
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last good received byte
DATA_VALID  output  1  one-cycle strobe; P_DATA updated this cycle
PAR_ERR  output  1  one-cycle strobe; parity mismatch on the frame just ended
STP_ERR  output  1  one-cycle strobe; stop bit sampled as 0

Behaviour:
- Clock and reset: one clock CLK. RST is synchronous and active-high. Reset forces all outputs to 0, the FSM to IDLE, all counters to 0, and the synchroniser flops to 1.
- Input sync: RX_IN passes through SYNC_STAGES flops; rx_s is the synchronised line. All sampling uses rx_s.
- Config latch: PRESCALE, PAR_EN and PAR_TYP are captured in the IDLE->START cycle and held for the whole frame. Mid-frame changes are ignored. An illegal PRESCALE value is latched as 8.
- Edge counter: counts 0..PRESCALE-1 within each bit and wraps to 0 at bit end.
- Bit counter: counts data bits 0..DATA_WIDTH-1.
- Sampling: take rx_s at edge counts P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, registered at P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 -> START. That cycle is edge 0 of the start bit.
  - START: at edge P/2+1, a sampled bit of 1 is a glitch -> IDLE, no outputs asserted. Otherwise at edge P-1 -> DATA.
  - DATA: the sampled bit shifts into the shift register, LSB first. At edge P-1 of bit DATA_WIDTH-1 -> PARITY if PAR_EN=1, else STOP.
  - PARITY: expected parity = XOR(data) ^ PAR_TYP. A mismatch sets an internal par_fail flag. At edge P-1 -> STOP.
  - STOP: at edge P-1 -> IDLE, and the frame-end event fires.
- Frame end, on the next clock after the event:
  - Always: STP_ERR = (stop sample==0); PAR_ERR = par_fail.
  - Only if both flags are 0: DATA_VALID=1 and P_DATA <= shift register.
  - Otherwise P_DATA keeps its previous value.
  - All strobes last exactly one cycle.
- Latency: DATA_VALID rises exactly PRESCALE*N cycles after the IDLE detect cycle, where N=10 (PAR_EN=0) or 11 (PAR_EN=1).
- Back-to-back frames: FSM is in IDLE in the same cycle the strobe is high. If rx_s==0 there, the next start is detected immediately with no dead cycle.
- Line held low after a stop error (break): a new frame is started each time the FSM reaches IDLE, so framing errors repeat until the line returns high.
- Reset mid-frame: the partial frame is discarded; no strobe is generated.
- par_fail clears on START entry.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - PRESCALE_8/16/32 constants
  - PAR_EVEN=0 / PAR_ODD=1
  - Frame bit-count constants, shared with the TX side
- One sub-module, uart_rx_sampler: holds the edge counter, the 3-point majority sampler and the sample_done / bit_end pulses. The FSM, shift register, parity check and outputs stay in uart_rx_core.

Test Plan:
- PRESCALE=8, PAR_EN=0, send 0xA5 -> DATA_VALID for 1 cycle exactly 80 cycles after detect; P_DATA=0xA5; PAR_ERR=STP_ERR=0.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> DATA_VALID at detect+176 cycles, P_DATA=0x3C. Repeat with parity bit 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA still 0x3C.
- PRESCALE=32, PAR_EN=1, PAR_TYP=1, send 0xFF with stop bit 0 -> STP_ERR pulse, no DATA_VALID. Also drive one sample of noise at edge P/2 of each data bit -> majority vote rejects it; 0x81 with parity 1 is received correctly.
- Start-bit glitch (RX_IN low for 3 cycles at PRESCALE=8) -> FSM returns to IDLE; no strobes. A following valid 0x55 frame is received.
- Back-to-back 0x01, 0x80 with no idle gap (PRESCALE=8) -> two DATA_VALID pulses exactly 80 cycles apart, with matching data.
- RST asserted in DATA after 4 bits -> next cycle all outputs 0 and FSM in IDLE. A subsequent full frame of 0xC3 is received correctly.
